// File: rtl/game_sequencer_if.sv
// Control/status bundle between the input controls, the game sequencer and
// the trajectory / target / display datapath.
interface game_sequencer_if;
    logic       start_new_game;
    logic       shoot_req;
    logic       result_valid;
    logic       hit;
    logic [4:0] user_select;
    logic       shoot_out;
    logic       new_target;
    logic [4:0] select_out;
    logic       game_active;
    logic       game_over;
    logic [3:0] score;
    logic [3:0] shots_left;

    // Controls and datapath side: drives requests, observes sequencer status.
    modport master (
        output start_new_game, shoot_req, result_valid, hit, user_select,
        input  shoot_out, new_target, select_out, game_active, game_over,
        input  score, shots_left
    );

    // Sequencer side.
    modport slave (
        input  start_new_game, shoot_req, result_valid, hit, user_select,
        output shoot_out, new_target, select_out, game_active, game_over,
        output score, shots_left
    );
endinterface

// File: rtl/game_sequencer.sv
// Round/game controller for the cannon-and-target datapath: reveals each new
// target, arms the cannon, issues shoot pulses, scores results, ends the game.
// Optional macro SEQ_TIMEOUT_EN: adds an IN_FLIGHT timeout that forces a miss
// after FLIGHT_TIMEOUT cycles without a trajectory result.
module game_sequencer #(
    parameter int SHOTS_PER_GAME = 8,
    parameter int DISP_CYCLES    = 16,
    parameter int FLIGHT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    game_sequencer_if.slave  bus
);
    localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_NEW_TARGET, S_SHOW_X, S_SHOW_Y,
        S_ARMED, S_IN_FLIGHT, S_RESULT, S_GAME_OVER
    } state_t;

    state_t        state, nxt;
    logic [DW-1:0] disp_cnt;
    logic          disp_last;
    logic          hit_q;
    logic          flight_expire;

    // Out-of-range parameters elaborate an empty marker scope that shows up
    // in the hierarchy, which makes a bad configuration easy to spot.
    if (SHOTS_PER_GAME < 1 || SHOTS_PER_GAME > 15 || DISP_CYCLES < 1 ||
        FLIGHT_TIMEOUT < 2) begin : g_bad_params
    end

    assign disp_last = (disp_cnt == DW'(DISP_CYCLES - 1));

`ifdef SEQ_TIMEOUT_EN
    localparam int FW = $clog2(FLIGHT_TIMEOUT);
    logic [FW-1:0] flight_cnt;

    assign flight_expire = (flight_cnt == FW'(FLIGHT_TIMEOUT - 1));

    // Counts IN_FLIGHT cycles; restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (!rst_n)
            flight_cnt <= '0;
        else if (state == S_IN_FLIGHT && nxt == S_IN_FLIGHT)
            flight_cnt <= flight_cnt + FW'(1);
        else
            flight_cnt <= '0;
    end
`else
    // Without the timeout a shot in flight waits for its result forever.
    assign flight_expire = 1'b0;
`endif

    // Next-state decode; restart beats every other transition.
    always_comb begin
        nxt = state;
        if (bus.start_new_game) begin
            nxt = S_NEW_TARGET;
        end else begin
            case (state)
                S_IDLE:       nxt = S_IDLE;
                S_NEW_TARGET: nxt = S_SHOW_X;
                S_SHOW_X:     if (disp_last) nxt = S_SHOW_Y;
                S_SHOW_Y:     if (disp_last) nxt = S_ARMED;
                S_ARMED:      if (bus.shoot_req) nxt = S_IN_FLIGHT;
                // A result arriving on the expiry edge is taken as a real result.
                S_IN_FLIGHT:  if (bus.result_valid || flight_expire) nxt = S_RESULT;
                S_RESULT: begin
                    if (bus.shots_left == 4'd0) nxt = S_GAME_OVER;
                    else if (hit_q)             nxt = S_NEW_TARGET;
                    else                        nxt = S_ARMED;
                end
                S_GAME_OVER:  nxt = S_GAME_OVER;
                default:      nxt = S_IDLE;
            endcase
        end
    end

    // State register plus outputs decoded from the next state so every
    // output lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bus.shoot_out   <= 1'b0;
            bus.new_target  <= 1'b0;
            bus.game_active <= 1'b0;
            bus.game_over   <= 1'b0;
            bus.select_out  <= 5'b0;
            bus.score       <= 4'd0;
            bus.shots_left  <= 4'(SHOTS_PER_GAME);
            disp_cnt        <= '0;
            hit_q           <= 1'b0;
        end else begin
            state           <= nxt;
            bus.shoot_out   <= (state == S_ARMED) && (nxt == S_IN_FLIGHT);
            bus.new_target  <= (nxt == S_NEW_TARGET);
            bus.game_active <= (nxt != S_IDLE) && (nxt != S_GAME_OVER);
            bus.game_over   <= (nxt == S_GAME_OVER);
            case (nxt)
                S_SHOW_X:                      bus.select_out <= 5'b00100;
                S_SHOW_Y:                      bus.select_out <= 5'b00010;
                S_IN_FLIGHT:                   bus.select_out <= 5'b00001;
                S_IDLE, S_ARMED, S_GAME_OVER:  bus.select_out <= bus.user_select;
                default:                       bus.select_out <= 5'b0;
            endcase
            disp_cnt <= (nxt == state && (state == S_SHOW_X || state == S_SHOW_Y))
                        ? disp_cnt + DW'(1) : '0;
            if (bus.start_new_game) begin
                bus.score      <= 4'd0;
                bus.shots_left <= 4'(SHOTS_PER_GAME);
                hit_q          <= 1'b0;
            end else begin
                if (state == S_ARMED && nxt == S_IN_FLIGHT)
                    bus.shots_left <= bus.shots_left - 4'd1;
                if (state == S_IN_FLIGHT && nxt == S_RESULT) begin
                    hit_q <= bus.result_valid & bus.hit;
                    if (bus.result_valid && bus.hit && bus.score != 4'd15)
                        bus.score <= bus.score + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: the stimulus process plays games with
// random shot outcomes and pushes expected events (new target, shot, game
// over) with the expected score/shots; a monitor pops them on each DUT pulse.
module tb_game_sequencer;
    localparam int SHOTS = 8;
    localparam int DISP  = 16;
    localparam int FTO   = 64;

    localparam int EV_NT   = 0;
    localparam int EV_SHOT = 1;
    localparam int EV_GO   = 2;

    typedef struct {
        int kind;
        int score;
        int shots;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    game_sequencer_if bus();

    game_sequencer #(.SHOTS_PER_GAME(SHOTS), .DISP_CYCLES(DISP), .FLIGHT_TIMEOUT(FTO))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    int   m_score;
    int   m_shots;
    logic [4:0] cur_sel;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input int kind);
        exp_t e;
        e.kind  = kind;
        e.score = m_score;
        e.shots = m_shots;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("unexpected_event", kind, -1);
            return;
        end
        e = sb_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_score", int'(bus.score), e.score);
        check("event_shots", int'(bus.shots_left), e.shots);
    endtask

    // Monitor: every output pulse must match the next expected event.
    logic prev_nt = 1'b0, prev_so = 1'b0, prev_go = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.new_target || bus.shoot_out)
                check("pulse_exclusive", int'(bus.new_target & bus.shoot_out), 0);
            if (bus.new_target) begin
                check("nt_single_cycle", int'(prev_nt), 0);
                sb_pop(EV_NT);
            end
            if (bus.shoot_out) begin
                check("shoot_single_cycle", int'(prev_so), 0);
                sb_pop(EV_SHOT);
            end
            if (bus.game_over && !prev_go)
                sb_pop(EV_GO);
        end
        prev_nt <= bus.new_target;
        prev_so <= bus.shoot_out;
        prev_go <= bus.game_over;
    end

    // Called at the NEW_TARGET negedge; ends at the first ARMED negedge.
    task automatic check_reveal();
        int nx = 0, ny = 0, guard = 0;
        @(negedge clk);
        bus.result_valid = 1'b0;
        bus.hit          = 1'b0;
        while (bus.select_out == 5'b00100 && guard < 100) begin
            nx++; guard++; @(negedge clk);
        end
        while (bus.select_out == 5'b00010 && guard < 100) begin
            ny++; guard++; @(negedge clk);
        end
        check("reveal_x_cycles", nx, DISP);
        check("reveal_y_cycles", ny, DISP);
        check("armed_select", int'(bus.select_out), int'(cur_sel));
        check("armed_active", int'(bus.game_active), 1);
        check("armed_score", int'(bus.score), m_score);
        check("armed_shots", int'(bus.shots_left), m_shots);
    endtask

    // Pulses start_new_game; optionally throws a late result during NEW_TARGET.
    task automatic start_game(input bit late_result);
        m_score = 0;
        m_shots = SHOTS;
        cur_sel = ($urandom_range(0, 1) != 0) ? 5'b01000 : 5'b10000;
        bus.user_select = cur_sel;
        sb_push(EV_NT);
        bus.start_new_game = 1'b1;
        bus.shoot_req      = 1'b0;
        @(negedge clk);
        bus.start_new_game = 1'b0;
        if (late_result) begin
            bus.result_valid = 1'b1;
            bus.hit          = 1'b1;
        end
    endtask

    // From ARMED: request a shot; ends at the first IN_FLIGHT negedge.
    task automatic fire();
        m_shots--;
        sb_push(EV_SHOT);
        bus.shoot_req = 1'b1;
        @(negedge clk);
        bus.shoot_req = 1'b0;
        check("flight_select", int'(bus.select_out), 5'b00001);
    endtask

    // Called at the RESULT negedge: score and route to the next phase.
    task automatic finish_result(input bit h);
        if (h && m_score < 15) m_score++;
        check("result_score", int'(bus.score), m_score);
        check("result_active", int'(bus.game_active), 1);
        if (m_shots == 0) begin
            sb_push(EV_GO);
            @(negedge clk);
        end else if (h) begin
            sb_push(EV_NT);
            @(negedge clk);
            check_reveal();
        end else begin
            @(negedge clk);
            check("miss_armed_select", int'(bus.select_out), int'(cur_sel));
            check("miss_no_new_target", int'(bus.new_target), 0);
            check("miss_shots", int'(bus.shots_left), m_shots);
        end
    endtask

    // In-flight noise on shoot_req/hit, then the trajectory result strobe.
    task automatic resolve(input bit h, input int d);
        for (int i = 0; i < d; i++) begin
            bus.shoot_req = 1'($urandom_range(0, 1));
            bus.hit       = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.shoot_req    = 1'b0;
        bus.result_valid = 1'b1;
        bus.hit          = h;
        @(negedge clk);
        bus.result_valid = 1'b0;
        bus.hit          = 1'b0;
        finish_result(h);
    endtask

    task automatic shoot(input bit h, input int d);
        fire();
        resolve(h, d);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.start_new_game = 1'b0;
        bus.shoot_req      = 1'b0;
        bus.result_valid   = 1'b0;
        bus.hit            = 1'b0;
        cur_sel            = 5'b10000;
        bus.user_select    = cur_sel;
        m_score = 0;
        m_shots = SHOTS;
        repeat (3) @(negedge clk);
        check("rst_shots_left", int'(bus.shots_left), SHOTS);
        check("rst_score", int'(bus.score), 0);
        check("rst_select", int'(bus.select_out), 0);
        check("rst_flags", int'({bus.shoot_out, bus.new_target, bus.game_active, bus.game_over}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_select", int'(bus.select_out), int'(cur_sel));
        check("idle_active", int'(bus.game_active), 0);

        // Start, one hit (re-reveal), one miss (straight back to ARMED).
        start_game(1'b0);
        check_reveal();
        shoot(1'b1, 3);
        shoot(1'b0, 5);

        // Shot with no result.
        fire();
`ifdef SEQ_TIMEOUT_EN
        n = 0;
        while (bus.select_out == 5'b00001 && n < 300) begin
            n++; @(negedge clk);
        end
        check("timeout_flight_cycles", n, FTO);
        finish_result(1'b0);
        fire();
        repeat (4) @(negedge clk);
`else
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.select_out == 5'b00001 && bus.game_active) n++;
        end
        check("no_timeout_still_flying", n, 200);
`endif

        // Restart mid-flight; a late hit result must be dropped.
        start_game(1'b1);
        check_reveal();

        // A whole game of misses ends in GAME_OVER; further shots do nothing.
        for (int s = 0; s < SHOTS; s++) shoot(1'b0, int'($urandom_range(0, 12)));
        check("go_flag", int'(bus.game_over), 1);
        check("go_active", int'(bus.game_active), 0);
        check("go_shots", int'(bus.shots_left), 0);
        check("go_score", int'(bus.score), 0);
        bus.shoot_req = 1'b1;
        @(negedge clk);
        bus.shoot_req = 1'b0;
        repeat (4) @(negedge clk);
        check("go_hold", int'(bus.game_over), 1);
        check("go_select", int'(bus.select_out), int'(cur_sel));

        // Random game.
        start_game(1'b0);
        check_reveal();
        while (m_shots > 0)
            shoot(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
        check("rand_go_flag", int'(bus.game_over), 1);
        check("rand_go_score", int'(bus.score), m_score);

        // Reset pulse in the middle of SHOW_Y.
        start_game(1'b0);
        repeat (DISP + 4) @(negedge clk);
        check("pre_rst_in_show_y", int'(bus.select_out), 5'b00010);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_select", int'(bus.select_out), 0);
        check("rst2_score", int'(bus.score), 0);
        check("rst2_shots", int'(bus.shots_left), SHOTS);
        check("rst2_flags", int'({bus.shoot_out, bus.new_target, bus.game_active, bus.game_over}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_idle_active", int'(bus.game_active), 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
